// File: rtl/mem_bank_arr_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared types and defaults for the per-row scratchpad bank array.
//   Imported by the interface, the single-bank module and the top level.
//
//   Contents:
//     rd_lat_e     - read latency mode (raw array output or extra register)
//     clr_state_e  - states of the zero-fill clear engine
//     DEF_*        - default parameter values (16 banks x 256 x 16 bits)
//     addr_w()     - address width for a given depth (never below 1 bit)
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [0:0] {
    LAT1 = 1'b0,
    LAT2 = 1'b1
  } rd_lat_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int DEF_NUM_BANKS   = 16;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_RD_LAT      = 1;
  localparam int DEF_WRITE_FIRST = 0;

  // A depth of 2 still needs one address bit, so clamp at 1.
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_arr_if.sv
// ---------------------------------------------------------------------------
// mem_bank_arr_if
//   Bundles the per-bank read/write ports and the clear-engine handshake of
//   mem_bank_arr.
//
//   master : loaders / array side (drives requests, observes results)
//   slave  : mem_bank_arr (accepts requests, returns read data and status)
//
//   Signals:
//     rd_en     [NUM_BANKS]                per-bank read request
//     rd_addr   [0:NUM_BANKS-1][ADDR_W]    read address
//     wr_en     [NUM_BANKS]                per-bank write request
//     wr_addr   [0:NUM_BANKS-1][ADDR_W]    write address
//     wr_data   [0:NUM_BANKS-1][DATA_W]    write data
//     rd_valid  [NUM_BANKS]                rd_data[i] valid this cycle
//     rd_data   [0:NUM_BANKS-1][DATA_W]    read data (held between reads)
//     clr_start                            one-cycle pulse: zero-fill all banks
//     clr_busy                             clear engine active
//     clr_done                             one-cycle pulse at end of clear
// ---------------------------------------------------------------------------
interface mem_bank_arr_if
  import mem_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);

  localparam int ADDR_W = addr_w(DEPTH);

  logic [NUM_BANKS-1:0]  rd_en;
  logic [ADDR_W-1:0]     rd_addr [0:NUM_BANKS-1];
  logic [NUM_BANKS-1:0]  wr_en;
  logic [ADDR_W-1:0]     wr_addr [0:NUM_BANKS-1];
  logic [DATA_WIDTH-1:0] wr_data [0:NUM_BANKS-1];
  logic [NUM_BANKS-1:0]  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data [0:NUM_BANKS-1];
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_start,
    input  rd_valid, rd_data, clr_busy, clr_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_start,
    output rd_valid, rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/mem_bank_arr_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
//   One 1R1W bank of DEPTH x DATA_WIDTH inferred storage with a same-address
//   collision mux, an RD_LAT-deep read pipeline and a matching valid bit.
//
//   Ports:
//     clk, rst   rising-edge clock, synchronous active-high reset
//     rd_en      read request; result appears RD_LAT edges later
//     rd_addr    read address (>= DEPTH reads back as zero)
//     wr_en      write request (>= DEPTH is silently dropped)
//     wr_addr    write address
//     wr_data    write data
//     rd_valid   one-cycle strobe per accepted read
//     rd_data    read result, held while rd_valid is low
//
//   Storage is never reset; only the read pipeline is cleared by rst.
// ---------------------------------------------------------------------------
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = addr_w(DEF_DEPTH),
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int WRITE_FIRST = DEF_WRITE_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam rd_lat_e LAT_MODE = (RD_LAT >= 2) ? LAT2 : LAT1;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // A power-of-two depth has no unused addresses, so the range check would
  // be a constant; only build the comparator when holes in the address space
  // actually exist.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_partial_range
      localparam logic [ADDR_W:0] DEPTH_EXT = DEPTH[ADDR_W:0];
      assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
      assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    end
  endgenerate

  assign wr_ok = wr_en && wr_in_range;

  // Plain storage write port; out-of-range writes never reach the array.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Word presented to the first pipeline stage. In write-first mode a
  // same-address write bypasses the array; otherwise the non-blocking array
  // update naturally yields the pre-write contents.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((WRITE_FIRST != 0) && wr_ok && (wr_addr == rd_addr)) begin
        rd_word = wr_data;
      end else begin
        rd_word = mem[rd_addr];
      end
    end
  end

  // First stage: the registered array output. Data only moves on a read so
  // the last result is held between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (LAT_MODE == LAT2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // Optional output register, again advancing only on valid data.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: rtl/mem_bank_arr.sv
// ---------------------------------------------------------------------------
// mem_bank_arr
//   NUM_BANKS independent 1R1W scratchpad banks, one per systolic-array row,
//   plus a clear engine that zero-fills every bank one address per cycle.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (aborts a clear in progress)
//     bus   mem_bank_arr_if.slave: per-bank read/write ports, clr_start,
//           rd_valid/rd_data, clr_busy, clr_done
//
//   While the clear engine is busy it owns every bank's write port, user
//   writes are dropped and new user reads are ignored; reads already in the
//   bank pipelines still complete.
// ---------------------------------------------------------------------------
module mem_bank_arr
  import mem_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int WRITE_FIRST = DEF_WRITE_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  mem_bank_arr_if.slave bus
);

  localparam int                ADDR_W    = addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy;
  logic              done;
  logic              clear_we;

  logic [NUM_BANKS-1:0]  bk_rd_en;
  logic [NUM_BANKS-1:0]  bk_wr_en;
  logic [ADDR_W-1:0]     bk_wr_addr  [0:NUM_BANKS-1];
  logic [DATA_WIDTH-1:0] bk_wr_data  [0:NUM_BANKS-1];
  logic [NUM_BANKS-1:0]  bk_rd_valid;
  logic [DATA_WIDTH-1:0] bk_rd_data  [0:NUM_BANKS-1];

  // Clear engine state and address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // CLEAR visits every address exactly once (DEPTH cycles), then DONE holds
  // for a single cycle so clr_done is a clean pulse. clr_start is only
  // looked at in IDLE, which is what makes a repeated start harmless.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    clear_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.clr_busy = busy;
  assign bus.clr_done = done;

  // Per-bank port steering. The clear write is also held off by rst so an
  // aborted clear leaves the address it was about to zero untouched.
  generate
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      assign bk_rd_en[i]   = busy ? 1'b0 : bus.rd_en[i];
      assign bk_wr_en[i]   = busy ? (clear_we && !rst) : bus.wr_en[i];
      assign bk_wr_addr[i] = busy ? cnt_q : bus.wr_addr[i];
      assign bk_wr_data[i] = busy ? '0 : bus.wr_data[i];

      mem_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .WRITE_FIRST (WRITE_FIRST)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (bk_rd_en[i]),
        .rd_addr  (bus.rd_addr[i]),
        .wr_en    (bk_wr_en[i]),
        .wr_addr  (bk_wr_addr[i]),
        .wr_data  (bk_wr_data[i]),
        .rd_valid (bk_rd_valid[i]),
        .rd_data  (bk_rd_data[i])
      );
    end
  endgenerate

  assign bus.rd_valid = bk_rd_valid;
  assign bus.rd_data  = bk_rd_data;

endmodule

// File: tb/tb_mem_bank_arr.sv
// ---------------------------------------------------------------------------
// tb_mem_bank_arr
//   Two instances of mem_bank_arr:
//     dut_a : defaults (16 banks x 256 x 16, RD_LAT=1, read-old collisions)
//     dut_b : 4 banks x 20 words, RD_LAT=2, write-first collisions
//   Inputs change 1ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_mem_bank_arr;

  localparam int A_BANKS = 16;
  localparam int A_DEPTH = 256;
  localparam int B_BANKS = 4;
  localparam int B_DEPTH = 20;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_bank_arr_if #(.NUM_BANKS(A_BANKS), .DATA_WIDTH(16), .DEPTH(A_DEPTH)) bus_a ();
  mem_bank_arr_if #(.NUM_BANKS(B_BANKS), .DATA_WIDTH(16), .DEPTH(B_DEPTH)) bus_b ();

  mem_bank_arr #(
    .NUM_BANKS(A_BANKS), .DATA_WIDTH(16), .DEPTH(A_DEPTH), .RD_LAT(1), .WRITE_FIRST(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_bank_arr #(
    .NUM_BANKS(B_BANKS), .DATA_WIDTH(16), .DEPTH(B_DEPTH), .RD_LAT(2), .WRITE_FIRST(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    logic        wr;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        rd;
    logic [7:0]  raddr;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.rd_en     = '0;
    bus_a.wr_en     = '0;
    bus_a.clr_start = 1'b0;
    for (int b = 0; b < A_BANKS; b++) begin
      bus_a.rd_addr[b] = '0;
      bus_a.wr_addr[b] = '0;
      bus_a.wr_data[b] = '0;
    end
  endtask

  task automatic idle_b();
    bus_b.rd_en     = '0;
    bus_b.wr_en     = '0;
    bus_b.clr_start = 1'b0;
    for (int b = 0; b < B_BANKS; b++) begin
      bus_b.rd_addr[b] = '0;
      bus_b.wr_addr[b] = '0;
      bus_b.wr_data[b] = '0;
    end
  endtask

  // Drive one table row onto dut_a and advance one edge.
  task automatic applyStimulus(input vec_t v);
    idle_a();
    bus_a.wr_en[v.bank]   = v.wr;
    bus_a.wr_addr[v.bank] = v.waddr;
    bus_a.wr_data[v.bank] = v.wdata;
    bus_a.rd_en[v.bank]   = v.rd;
    bus_a.rd_addr[v.bank] = v.raddr;
    tick();
  endtask

  // sel 0: per-bank/address pattern, 1: zero, 2: all ones
  function automatic logic [15:0] pat(input int b, input int a, input int sel);
    logic [3:0] bb;
    logic [7:0] aa;
    bb = b[3:0];
    aa = a[7:0];
    case (sel)
      0:       return {bb, aa, aa[3:0] ^ bb};
      1:       return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic fill_a(input int sel);
    for (int a = 0; a < A_DEPTH; a++) begin
      bus_a.wr_en = '1;
      for (int b = 0; b < A_BANKS; b++) begin
        bus_a.wr_addr[b] = a[7:0];
        bus_a.wr_data[b] = pat(b, a, sel);
      end
      tick();
    end
    bus_a.wr_en = '0;
  endtask

  // Back-to-back reads of every address on every bank.
  task automatic read_all_a(input int sel, input string tag);
    for (int a = 0; a < A_DEPTH; a++) begin
      bus_a.rd_en = '1;
      for (int b = 0; b < A_BANKS; b++) bus_a.rd_addr[b] = a[7:0];
      tick();
      for (int b = 0; b < A_BANKS; b++) begin
        checkOutput({tag, "_valid"}, 32'(bus_a.rd_valid[b]), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus_a.rd_data[b]), 32'(pat(b, a, sel)));
      end
    end
    bus_a.rd_en = '0;
    tick();
    checkOutput({tag, "_end_valid"}, 32'(bus_a.rd_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int valid_seen;

    n_cmp = 0;
    n_err = 0;
    tbl[0]  = '{3,  1'b1, 8'h10, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h0000};
    tbl[1]  = '{3,  1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 1'b1, 16'hBEEF};
    tbl[2]  = '{3,  1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hBEEF};
    tbl[3]  = '{0,  1'b1, 8'h05, 16'h1111, 1'b0, 8'h00, 1'b0, 16'h0000};
    tbl[4]  = '{0,  1'b1, 8'h05, 16'h2222, 1'b1, 8'h05, 1'b1, 16'h1111};
    tbl[5]  = '{0,  1'b0, 8'h00, 16'h0000, 1'b1, 8'h05, 1'b1, 16'h2222};
    tbl[6]  = '{0,  1'b1, 8'h06, 16'h3333, 1'b1, 8'h05, 1'b1, 16'h2222};
    tbl[7]  = '{0,  1'b0, 8'h00, 16'h0000, 1'b1, 8'h06, 1'b1, 16'h3333};
    tbl[8]  = '{15, 1'b1, 8'hFF, 16'h5A5A, 1'b0, 8'h00, 1'b0, 16'h0000};
    tbl[9]  = '{15, 1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b1, 16'h5A5A};
    tbl[10] = '{15, 1'b1, 8'h00, 16'h0001, 1'b1, 8'hFF, 1'b1, 16'h5A5A};
    tbl[11] = '{15, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b1, 16'h0001};

    // ---- reset with reads requested ----
    idle_a();
    idle_b();
    bus_a.rd_en = '1;
    bus_b.rd_en = '1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_valid_a", 32'(bus_a.rd_valid), 32'd0);
      checkOutput("rst_data_a3", 32'(bus_a.rd_data[3]), 32'd0);
      checkOutput("rst_busy_a", 32'(bus_a.clr_busy), 32'd0);
      checkOutput("rst_valid_b", 32'(bus_b.rd_valid), 32'd0);
    end
    rst = 1'b0;
    idle_a();
    idle_b();
    tick();
    checkOutput("post_rst_valid_a", 32'(bus_a.rd_valid), 32'd0);
    checkOutput("post_rst_data_a0", 32'(bus_a.rd_data[0]), 32'd0);
    checkOutput("post_rst_busy_a", 32'(bus_a.clr_busy), 32'd0);
    checkOutput("post_rst_done_a", 32'(bus_a.clr_done), 32'd0);

    // ---- table: basic R/W, read-old collision, hold (RD_LAT=1) ----
    for (int i = 0; i < 12; i++) begin
      logic [15:0] others;
      applyStimulus(tbl[i]);
      others = bus_a.rd_valid;
      others[tbl[i].bank] = 1'b0;
      checkOutput($sformatf("tbl%0d_valid", i), 32'(bus_a.rd_valid[tbl[i].bank]), 32'(tbl[i].exp_v));
      checkOutput($sformatf("tbl%0d_data", i), 32'(bus_a.rd_data[tbl[i].bank]), 32'(tbl[i].exp_d));
      checkOutput($sformatf("tbl%0d_others", i), 32'(others), 32'd0);
    end
    idle_a();

    // ---- dut_b: RD_LAT=2 basic read ----
    bus_b.wr_en[3] = 1'b1; bus_b.wr_addr[3] = 5'd16; bus_b.wr_data[3] = 16'hBEEF;
    tick();
    idle_b();
    bus_b.rd_en[3] = 1'b1; bus_b.rd_addr[3] = 5'd16;
    tick();
    idle_b();
    checkOutput("b_lat2_early_valid", 32'(bus_b.rd_valid), 32'd0);
    tick();
    checkOutput("b_lat2_valid", 32'(bus_b.rd_valid), 32'b1000);
    checkOutput("b_lat2_data", 32'(bus_b.rd_data[3]), 32'hBEEF);
    tick();
    checkOutput("b_lat2_once", 32'(bus_b.rd_valid), 32'd0);
    checkOutput("b_lat2_hold", 32'(bus_b.rd_data[3]), 32'hBEEF);

    // ---- dut_b: write-first collision ----
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0] = 5'd5; bus_b.wr_data[0] = 16'h1111;
    tick();
    bus_b.wr_data[0] = 16'h2222;
    bus_b.rd_en[0] = 1'b1; bus_b.rd_addr[0] = 5'd5;
    tick();
    idle_b();
    tick();
    checkOutput("b_coll_valid", 32'(bus_b.rd_valid), 32'b0001);
    checkOutput("b_coll_data", 32'(bus_b.rd_data[0]), 32'h2222);
    bus_b.rd_en[0] = 1'b1; bus_b.rd_addr[0] = 5'd5;
    bus_b.wr_en[0] = 1'b1; bus_b.wr_addr[0] = 5'd6; bus_b.wr_data[0] = 16'h6666;
    tick();
    idle_b();
    tick();
    checkOutput("b_after_coll_data", 32'(bus_b.rd_data[0]), 32'h2222);

    // ---- dut_b: out-of-range address ----
    bus_b.wr_en[1] = 1'b1; bus_b.wr_addr[1] = 5'd2; bus_b.wr_data[1] = 16'h0F0F;
    tick();
    bus_b.wr_addr[1] = 5'd25; bus_b.wr_data[1] = 16'h7777;
    bus_b.rd_en[1] = 1'b1; bus_b.rd_addr[1] = 5'd2;
    tick();
    idle_b();
    bus_b.rd_en[1] = 1'b1; bus_b.rd_addr[1] = 5'd25;
    tick();
    idle_b();
    checkOutput("b_inrange_data", 32'(bus_b.rd_data[1]), 32'h0F0F);
    tick();
    checkOutput("b_oor_valid", 32'(bus_b.rd_valid), 32'b0010);
    checkOutput("b_oor_data", 32'(bus_b.rd_data[1]), 32'h0000);

    // ---- dut_b: read in flight when clr_start arrives ----
    bus_b.wr_en[2] = 1'b1; bus_b.wr_addr[2] = 5'd4; bus_b.wr_data[2] = 16'h4444;
    tick();
    idle_b();
    bus_b.rd_en[2] = 1'b1; bus_b.rd_addr[2] = 5'd4;
    tick();
    idle_b();
    checkOutput("b_inflight_early", 32'(bus_b.rd_valid), 32'd0);
    bus_b.clr_start = 1'b1;
    tick();
    bus_b.clr_start = 1'b0;
    checkOutput("b_inflight_busy", 32'(bus_b.clr_busy), 32'd1);
    checkOutput("b_inflight_valid", 32'(bus_b.rd_valid), 32'b0100);
    checkOutput("b_inflight_data", 32'(bus_b.rd_data[2]), 32'h4444);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus_b.clr_busy) break;
      busy_cnt++;
      if (bus_b.clr_done) done_cnt++;
      tick();
    end
    checkOutput("b_clear_busy_cycles", 32'(busy_cnt), 32'(B_DEPTH + 1));
    checkOutput("b_clear_done_count", 32'(done_cnt), 32'd1);
    bus_b.rd_en[2] = 1'b1; bus_b.rd_addr[2] = 5'd4;
    tick();
    idle_b();
    tick();
    checkOutput("b_cleared_data", 32'(bus_b.rd_data[2]), 32'h0000);

    // ---- dut_a: streaming reads on all banks ----
    fill_a(0);
    read_all_a(0, "stream");

    // ---- dut_a: full clear with interference ----
    fill_a(2);
    bus_a.clr_start = 1'b1;
    tick();
    bus_a.clr_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = 0;
    valid_seen = 0;
    for (int c = 1; c <= A_DEPTH + 10; c++) begin
      if (!bus_a.clr_busy) break;
      busy_cnt++;
      if (bus_a.clr_done) begin
        done_cnt++;
        done_at = c;
      end
      if (bus_a.rd_valid != '0) valid_seen++;
      bus_a.rd_en = '1;
      bus_a.clr_start = (c == 10);
      bus_a.wr_en = '0;
      if (c == 100) begin
        bus_a.wr_en[2] = 1'b1;
        bus_a.wr_addr[2] = 8'd3;
        bus_a.wr_data[2] = 16'hAAAA;
      end
      tick();
    end
    idle_a();
    checkOutput("clear_busy_cycles", 32'(busy_cnt), 32'(A_DEPTH + 1));
    checkOutput("clear_done_count", 32'(done_cnt), 32'd1);
    checkOutput("clear_done_cycle", 32'(done_at), 32'(A_DEPTH + 1));
    checkOutput("clear_reads_ignored", 32'(valid_seen), 32'd0);
    read_all_a(1, "cleared");

    // ---- dut_a: reset aborts clear at counter 20 ----
    fill_a(2);
    bus_a.clr_start = 1'b1;
    tick();
    bus_a.clr_start = 1'b0;
    repeat (20) tick();
    checkOutput("abort_busy_before", 32'(bus_a.clr_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy_after", 32'(bus_a.clr_busy), 32'd0);
    for (int a = 0; a < 31; a++) begin
      bus_a.rd_en[5] = 1'b1;
      bus_a.rd_addr[5] = a[7:0];
      tick();
      checkOutput($sformatf("abort_addr%0d", a), 32'(bus_a.rd_data[5]), (a < 20) ? 32'h0 : 32'hFFFF);
    end
    idle_a();
    tick();
    checkOutput("abort_stays_idle", 32'({bus_a.clr_busy, bus_a.clr_done}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bank_arr.md
Name: mem_bank_arr

Overview:
Parametrised successor to the fixed 16x256 per-row scratchpad array. Provides NUM_BANKS independent 1R1W banks of DEPTH x DATA_WIDTH, one bank per systolic-array row, each built from inferred memory rather than vendor IP. Adds configurable read latency with a per-bank read-valid pipeline, defined same-address read/write collision semantics, and a hardware clear engine that zero-fills all banks. Sits between the row-data loaders and the systolic array row inputs.

Parameters:
NUM_BANKS, 16, number of banks (one per array row); at least 1
DATA_WIDTH, 16, bits per word
DEPTH, 256, words per bank; at least 2, need not be a power of 2
ADDR_W, $clog2(DEPTH), address width (derived; never overridden)
RD_LAT, 1, read latency in cycles; 1 = raw array output, 2 = adds an output register
WRITE_FIRST, 0, same-cycle same-address collision: 0 returns old data, 1 returns new write data

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
rd_en  in  NUM_BANKS  per-bank read request
rd_addr  in  ADDR_W x NUM_BANKS (unpacked [0:NUM_BANKS-1])  read address
wr_en  in  NUM_BANKS  per-bank write request
wr_addr  in  ADDR_W x NUM_BANKS  write address
wr_data  in  DATA_WIDTH x NUM_BANKS  write data
rd_valid  out  NUM_BANKS  rd_data[i] is valid this cycle
rd_data  out  DATA_WIDTH x NUM_BANKS  read data
clr_start  in  1  single-cycle pulse: zero-fill all banks
clr_busy  out  1  clear engine is active
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (synchronous, active-high): rd_valid=0, rd_data=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0, and the read pipeline is flushed. Memory contents are not reset.
- Write: when wr_en[i]=1, mem[i][wr_addr[i]] is updated at the clock edge.
- Read: a request with rd_en[i]=1 at edge N gives rd_valid[i]=1 and rd_data[i] at edge N+RD_LAT.
  - rd_valid[i] is high for exactly one cycle per request.
  - rd_data[i] holds its last value while rd_valid[i]=0.
  - Back-to-back requests give one result per cycle.
- Collision: rd_en and wr_en on the same bank and same address in the same cycle:
  - WRITE_FIRST=0: returns the pre-write data.
  - WRITE_FIRST=1: returns wr_data.
  - The memory is written in both modes.
  - Different addresses do not interact.
- Out-of-range address (>= DEPTH, when DEPTH is not a power of 2): the write is dropped; the read returns 0 with rd_valid still asserted.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start; clear counter := 0.
  - CLEAR: writes 0 to address counter in every bank each cycle; counter increments. At counter==DEPTH-1 the FSM moves to DONE.
  - CLEAR takes exactly DEPTH cycles.
  - DONE -> IDLE after one cycle; clr_done=1 only in DONE.
  - clr_busy=1 in CLEAR and DONE.
- While clr_busy=1:
  - clr_start is ignored.
  - User writes are dropped.
  - User reads are ignored (no rd_valid).
- Reads already in flight when clr_start arrives complete normally.
- Reset during CLEAR aborts to IDLE. Partially cleared contents are left as-is.

Decomposition:
- Package mem_pkg: rd_lat_e (LAT1, LAT2), clr_state_e (IDLE, CLEAR, DONE), default-parameter localparams, and an addr_w() helper function.
- Sub-module mem_bank: a single 1R1W bank containing the storage, collision mux, RD_LAT pipeline and valid bit. It is instantiated NUM_BANKS times in a generate loop.
- The top level holds only the clear FSM/counter and the per-bank port muxing between user and clear traffic.

Test Plan:
- Reset: hold rst for 3 cycles with rd_en=all-ones -> rd_valid=0, rd_data=0, clr_busy=0 throughout and 1 cycle after.
- Basic R/W, RD_LAT=1 and 2: write bank3 addr 0x10=0xBEEF, then read it -> rd_valid[3]=1 exactly RD_LAT cycles later with 0xBEEF; other banks' rd_valid stay 0.
- Collision: bank0 addr 5 holds 0x1111; same cycle write 0x2222 and read addr 5 -> 0x1111 when WRITE_FIRST=0, 0x2222 when WRITE_FIRST=1; a following read returns 0x2222 in both modes.
- Clear: fill all banks with 0xFFFF, pulse clr_start -> clr_busy high for DEPTH+1 cycles, clr_done pulses once at cycle DEPTH+1; afterwards every address in every bank reads 0. Writes of 0xAAAA issued mid-clear are lost.
- Clear interactions: second clr_start while busy is ignored (done pulse count=1); a read issued one cycle before clr_start still returns valid data. rst asserted at counter=20 gives clr_busy=0 next cycle, addrs 0-19 read 0, addr 20+ keep old data.
- Streaming: 256 back-to-back reads on all 16 banks -> 256 consecutive rd_valid cycles per bank, with data matching the reference model.
